unidade_busca: RTL and testbench
================================

// Module: unidade_busca
// PURPOSE
//  Instruction-fetch stage: owns the PC register and drives endereco_PC to i_mem.
//  Captures the returned instruction into the IF/ID pipeline register.
//  Next PC is sequential (PC+4) or a jump/branch redirect.
//  A redirect flushes the IF/ID register.
// PARAMETERS
//  PC_RESET         32'h0000_0000  PC value loaded on reset (word aligned)
//  MEMORIA_TAMANHO  64             instruction words in i_mem; addresses wrap modulo 4*MEMORIA_TAMANHO
// PORTS
//  clock            in   1   rising-edge clock
//  reset_n          in   1   asynchronous reset, active low
//  stall            in   1   hazard stall from ID; hold PC and IF/ID
//  jump             in   1   unconditional redirect request
//  jump_target      in   32  jump destination (byte address)
//  branch_taken     in   1   resolved taken branch from EX
//  branch_target    in   32  branch destination (byte address)
//  instrucao_in     in   32  instruction word from i_mem at endereco_PC (combinational)
//  endereco_PC      out  32  current PC, to i_mem
//  if_id_instrucao  out  32  registered instruction for ID
//  if_id_pc_mais4   out  32  registered PC+4 of that instruction
//  if_id_valido     out  1   1 = IF/ID holds a real instruction, 0 = bubble
//  erro_alinhamento out  1   sticky misaligned-target flag (FETCH_ALIGN_CHECK_EN only, else tied 0)
// BEHAVIOUR
//  - Reset (reset_n=0, async, takes effect immediately, also mid-operation):
//    endereco_PC=PC_RESET; if_id_instrucao=0 (NOP); if_id_pc_mais4=0; if_id_valido=0; erro_alinhamento=0.
//  - Per rising edge, priority order (first match wins):
//    1 branch_taken: PC<=branch_target; IF/ID<=bubble (instr 0, pc_mais4 0, valido 0).
//    2 jump:         PC<=jump_target;   IF/ID<=bubble.
//    3 stall:        PC and IF/ID hold their values.
//    4 otherwise:    PC<=PC+4; IF/ID<={instrucao_in, PC+4, 1}.
//  - branch_taken beats jump (branch is from the older instruction).
//    Any redirect beats stall: a stalled instruction is discarded by the flush.
//  - Fetch latency: an instruction appears on if_id_* one clock after its PC is on endereco_PC.
//    A redirect costs one bubble cycle.
//  - Address arithmetic is 32-bit unsigned.
//  - PC+4 and redirect targets are reduced modulo 4*MEMORIA_TAMANHO.
//    Example: the last word 4*(MEMORIA_TAMANHO-1) increments to 0.
//  - if_id_pc_mais4 carries the same wrapped value.
//  - Without FETCH_ALIGN_CHECK_EN, target[1:0] is forced to 2'b00 before loading the PC.
//  - endereco_PC is always word aligned.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined:
//    - If the selected redirect target has [1:0]!=0: PC holds, IF/ID<=bubble, erro_alinhamento<=1.
//    - erro_alinhamento is sticky until reset.
//    - While erro_alinhamento=1, PC holds and IF/ID stays bubble (fetch halted), ignoring all inputs.
//  FETCH_ALIGN_CHECK_EN undefined:
//    - No check; target low bits masked; erro_alinhamento constant 0.
// TESTING
//  1 Reset then release, i_mem words 0..3 = A,B,C,D, no control
//    -> endereco_PC 0,4,8,12; if_id_instrucao A,B,C one cycle later; pc_mais4 4,8,12; valido=1.
//  2 PC=8, stall=1 for 3 cycles
//    -> endereco_PC stays 8, if_id_* unchanged; after release resumes with 12.
//  3 PC=16, branch_taken=1, target=0x40, same cycle jump=1 target=0x80, stall=1
//    -> PC=0x40, valido=0 next cycle; then instr@0x40 valid.
//  4 MEMORIA_TAMANHO=64, PC=0xFC, no control
//    -> PC=0x000, if_id_pc_mais4=0x000 (wrap); jump_target=0x104 -> PC=0x004.
//  5 Assert reset_n=0 between clock edges while PC=0x20
//    -> all outputs reach reset values without a clock edge.
//  6 jump_target=0x22: undefined macro -> PC=0x20, no error.
//    Defined macro -> PC holds, erro_alinhamento=1, valido stays 0 until reset.

Source files
------------

// File: rtl/unidade_busca.sv
// Instruction-fetch stage: PC register, i_mem address and IF/ID pipeline register.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets halt fetch with a sticky error flag.
module unidade_busca #(
    parameter logic [31:0] PC_RESET        = 32'h0000_0000,
    parameter int unsigned MEMORIA_TAMANHO = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] instrucao_in,
    output logic [31:0] endereco_PC,
    output logic [31:0] if_id_instrucao,
    output logic [31:0] if_id_pc_mais4,
    output logic        if_id_valido,
    output logic        erro_alinhamento
);

    localparam logic [31:0] LIMITE = 32'(4 * MEMORIA_TAMANHO);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_mais4_q, pc_mais4_d;
    logic        valido_q, valido_d;
    logic        erro_q, erro_d;

    logic [31:0] alvo_bruto;
    logic [31:0] alvo;
    logic [31:0] pc_inc;
    logic [31:0] pc_seq;
    logic        redirect;
    logic        desalinhado;

    always_comb begin
        redirect   = branch_taken | jump;
        // branch comes from the older instruction, so it wins over jump
        alvo_bruto = branch_taken ? branch_target : jump_target;
        alvo       = (alvo_bruto & ~32'd3) % LIMITE;
        pc_inc     = pc_q + 32'd4;
        pc_seq     = (pc_inc >= LIMITE) ? (pc_inc - LIMITE) : pc_inc;
`ifdef FETCH_ALIGN_CHECK_EN
        desalinhado = (alvo_bruto[1:0] != 2'b00);
`else
        desalinhado = 1'b0;
`endif
    end

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_mais4_d = pc_mais4_q;
        valido_d   = valido_q;
        erro_d     = erro_q;

        if (erro_q) begin
            // fetch halted until reset; IF/ID already holds a bubble
            instr_d    = 32'd0;
            pc_mais4_d = 32'd0;
            valido_d   = 1'b0;
        end else if (redirect) begin
            if (desalinhado) begin
                erro_d = 1'b1;
            end else begin
                pc_d = alvo;
            end
            instr_d    = 32'd0;
            pc_mais4_d = 32'd0;
            valido_d   = 1'b0;
        end else if (!stall) begin
            pc_d       = pc_seq;
            instr_d    = instrucao_in;
            pc_mais4_d = pc_seq;
            valido_d   = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= PC_RESET;
            instr_q    <= 32'd0;
            pc_mais4_q <= 32'd0;
            valido_q   <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_mais4_q <= pc_mais4_d;
            valido_q   <= valido_d;
            erro_q     <= erro_d;
        end
    end

    assign endereco_PC      = pc_q;
    assign if_id_instrucao  = instr_q;
    assign if_id_pc_mais4   = pc_mais4_q;
    assign if_id_valido     = valido_q;
    assign erro_alinhamento = erro_q;

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: directed scenarios plus random control traffic against a
// behavioural fetch model; honours FETCH_ALIGN_CHECK_EN when defined.
module tb_unidade_busca;

    localparam int          MEM = 64;
    localparam logic [31:0] LIM = 32'd256;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall, jump, branch_taken;
    logic [31:0] jump_target, branch_target;
    logic [31:0] instrucao_in;
    logic [31:0] endereco_PC, if_id_instrucao, if_id_pc_mais4;
    logic        if_id_valido, erro_alinhamento;

    logic [31:0] mem [MEM];

    logic [31:0] m_pc, m_instr, m_pcm4;
    logic        m_val, m_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    assign instrucao_in = mem[int'((endereco_PC / 4) % MEM)];

    unidade_busca #(.PC_RESET(32'h0), .MEMORIA_TAMANHO(MEM)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .stall           (stall),
        .jump            (jump),
        .jump_target     (jump_target),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .instrucao_in    (instrucao_in),
        .endereco_PC     (endereco_PC),
        .if_id_instrucao (if_id_instrucao),
        .if_id_pc_mais4  (if_id_pc_mais4),
        .if_id_valido    (if_id_valido),
        .erro_alinhamento(erro_alinhamento)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},    endereco_PC,            m_pc);
        chk({tag, ".instr"}, if_id_instrucao,        m_instr);
        chk({tag, ".pcm4"},  if_id_pc_mais4,         m_pcm4);
        chk({tag, ".val"},   {31'd0, if_id_valido},  {31'd0, m_val});
        chk({tag, ".err"},   {31'd0, erro_alinhamento}, {31'd0, m_err});
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pcm4 = 32'h0; m_val = 1'b0; m_err = 1'b0;
    endtask

    // one clock: apply controls, predict the next state from the fetch rules, compare after the edge
    task automatic cycle(input string tag, input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt, input logic st);
        logic [31:0] tgt;
        logic        bad;
        branch_taken = br; branch_target = bt;
        jump = jp; jump_target = jt; stall = st;
        if (m_err) begin
            m_instr = 0; m_pcm4 = 0; m_val = 0;
        end else if (br || jp) begin
            tgt = br ? bt : jt;
            bad = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            bad = (tgt % 4) != 0;
`endif
            if (bad) m_err = 1'b1;
            else     m_pc = (tgt - (tgt % 4)) % LIM;
            m_instr = 0; m_pcm4 = 0; m_val = 0;
        end else if (!st) begin
            m_instr = mem[int'(m_pc / 4)];
            m_pcm4  = (m_pc + 4) % LIM;
            m_pc    = m_pcm4;
            m_val   = 1'b1;
        end
        @(posedge clock);
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        model_reset();
        #2;
        chk_all(tag);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < MEM; i++) mem[i] = $urandom;
        reset_n = 1'b0;
        stall = 0; jump = 0; branch_taken = 0;
        jump_target = 0; branch_target = 0;
        model_reset();
        #12;
        chk_all("rst");
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // sequential fetch of the first words
        for (int i = 0; i < 4; i++) cycle("seq", 0, 0, 0, 0, 0);

        // 3-cycle stall then resume
        for (int i = 0; i < 3; i++) cycle("stall", 0, 0, 0, 0, 1);
        cycle("resume", 0, 0, 0, 0, 0);

        // branch beats jump beats stall
        cycle("br_prio", 1, 32'h40, 1, 32'h80, 1);
        cycle("after_br", 0, 0, 0, 0, 0);
        cycle("after_br2", 0, 0, 0, 0, 0);
        cycle("jp_stall", 0, 0, 1, 32'h80, 1);

        // wrap at the end of memory and for out-of-range targets
        cycle("to_fc", 0, 0, 1, 32'hFC, 0);
        cycle("wrap", 0, 0, 0, 0, 0);
        cycle("wrap2", 0, 0, 0, 0, 0);
        cycle("tgt104", 0, 0, 1, 32'h104, 0);
        cycle("tgt104b", 0, 0, 0, 0, 0);

        // asynchronous reset between edges while PC=0x20
        cycle("to20", 0, 0, 1, 32'h20, 0);
        @(negedge clock);
        do_reset("async_rst");
        cycle("post_rst", 0, 0, 0, 0, 0);

        // misaligned target
        cycle("mis22", 0, 0, 1, 32'h22, 0);
        cycle("mis22b", 0, 0, 0, 0, 0);
        cycle("mis22c", 1, 32'h40, 0, 0, 0);
        @(negedge clock);
        do_reset("mis_rst");

        // random control traffic
        for (int n = 0; n < 400; n++) begin
            logic        br, jp, st;
            logic [31:0] bt, jt;
            br = ($urandom_range(0, 9) == 0);
            jp = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 4) == 0);
            bt = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'h3FF);
            jt = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'h3FC);
            cycle("rnd", br, bt, jp, jt, st);
            if (m_err && $urandom_range(0, 7) == 0) begin
                @(negedge clock);
                do_reset("rnd_rst");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
